// File: rtl/ans_decoder.sv
// -----------------------------------------------------------------------------
// ans_decoder
//
// Streaming rANS decoder, the receive-side counterpart of ans_encoder. The host
// loads a frequency table and an initial state, then issues START; the decoder
// emits (in+1) symbols, asking for renormalisation nibbles whenever the state
// drops below the normalised interval. Nibbles arrive in decode (LIFO) order.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous, active-high reset
//   in       in   input nibble
//   cmd      in   beat type: 00 FREQ, 01 STATE, 10 START/DATA, 11 ABORT
//   in_vld   in   input beat valid
//   in_rdy   out  decoder can take a beat (IDLE or RENORM)
//   out      out  decoded symbol
//   out_vld  out  decoded symbol valid
//   out_rdy  in   sink accepts symbol
//   err      out  sticky error: bad START or stray FREQ/STATE in RENORM
// -----------------------------------------------------------------------------
module ans_decoder #(
    parameter int DATA_WIDTH = 4,
    parameter int PROB_BITS  = 4,
    parameter int STATE_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in,
    input  logic [1:0]            cmd,
    input  logic                  in_vld,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic                  err
);

    localparam int NSYM  = 2 ** DATA_WIDTH;
    localparam int CUM_W = PROB_BITS + 1;
    // Wide enough to hold the sum of a fully loaded table without wrapping,
    // so an oversized table can never alias to a valid total.
    localparam int SUM_W = 2 * DATA_WIDTH;
    localparam int CMP_W = CUM_W + 1;

    localparam logic [STATE_BITS-1:0] L_MIN   = STATE_BITS'(2 ** (STATE_BITS - DATA_WIDTH));
    localparam logic [SUM_W-1:0]      M_TOTAL = SUM_W'(2 ** PROB_BITS);

    localparam logic [1:0] CMD_FREQ  = 2'b00;
    localparam logic [1:0] CMD_STATE = 2'b01;
    localparam logic [1:0] CMD_DATA  = 2'b10;
    localparam logic [1:0] CMD_ABORT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EMIT   = 2'd2,
        ST_RENORM = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  freq_q [NSYM];
    logic [DATA_WIDTH-1:0]  freq_d [NSYM];
    logic [DATA_WIDTH-1:0]  ptr_q, ptr_d;
    logic [STATE_BITS-1:0]  x_q, x_d;
    logic [STATE_BITS-1:0]  x_nx_q, x_nx_d;
    logic [DATA_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  out_q, out_d;
    logic                   out_vld_q, out_vld_d;
    logic                   err_q, err_d;

    logic [SUM_W-1:0]       tot_s;
    logic [CUM_W-1:0]       cum_s [NSYM];
    logic [PROB_BITS-1:0]   slot_s;
    logic [NSYM-1:0]        hit_s;
    logic [DATA_WIDTH-1:0]  sym_s;
    logic [STATE_BITS-1:0]  x_next_s;
    logic [STATE_BITS-1:0]  x_shift_s;
    logic                   start_ok_s;
    logic                   in_rdy_s;
    logic                   in_hs_s;

    assign slot_s    = x_q[PROB_BITS-1:0];
    assign x_shift_s = {x_q[STATE_BITS-DATA_WIDTH-1:0], in};

    // Exclusive prefix sums of the table (cum) and the full table total
    always_comb begin
        tot_s = '0;
        for (int s = 0; s < NSYM; s++) begin
            cum_s[s] = tot_s[CUM_W-1:0];
            tot_s    = tot_s + SUM_W'(freq_q[s]);
        end
    end

    // Slot-to-symbol lookup; zero-frequency symbols own no slot and never match
    always_comb begin
        hit_s = '0;
        sym_s = '0;
        for (int s = 0; s < NSYM; s++) begin
            hit_s[s] = (freq_q[s] != '0)
                    && (CMP_W'(slot_s) >= CMP_W'(cum_s[s]))
                    && (CMP_W'(slot_s) <  CMP_W'(cum_s[s]) + CMP_W'(freq_q[s]));
        end
        // Scan downwards so the lowest matching index wins if a bad table overlaps
        for (int s = NSYM - 1; s >= 0; s--) begin
            sym_s = hit_s[s] ? DATA_WIDTH'(s) : sym_s;
        end
    end

    // rANS state transition; modular arithmetic at STATE_BITS equals the
    // truncated full-width result, and a valid table never overflows anyway
    always_comb begin
        x_next_s = STATE_BITS'(freq_q[sym_s]) * (x_q >> PROB_BITS)
                 + STATE_BITS'(slot_s)
                 - STATE_BITS'(cum_s[sym_s]);
    end

    // START is only legal with a table summing to M and a normalised state
    always_comb begin
        start_ok_s = (tot_s == M_TOTAL) && (x_q >= L_MIN);
    end

    // Input readiness depends only on the FSM state
    always_comb begin
        in_rdy_s = (state_q == ST_IDLE) || (state_q == ST_RENORM);
        in_hs_s  = in_vld && in_rdy_s;
    end

    // Next-state and datapath update for the decode FSM
    always_comb begin
        state_d   = state_q;
        freq_d    = freq_q;
        ptr_d     = ptr_q;
        x_d       = x_q;
        x_nx_d    = x_nx_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        out_vld_d = out_vld_q;
        err_d     = err_q;

        case (state_q)
            ST_IDLE: begin
                if (in_hs_s) begin
                    case (cmd)
                        CMD_FREQ: begin
                            freq_d[ptr_q] = in;
                            ptr_d         = ptr_q + DATA_WIDTH'(1);
                        end
                        CMD_STATE: begin
                            x_d = x_shift_s;
                        end
                        CMD_ABORT: begin
                            ptr_d = '0;
                        end
                        CMD_DATA: begin
                            if (start_ok_s) begin
                                err_d   = 1'b0;
                                cnt_d   = in;
                                state_d = ST_DECODE;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_DECODE: begin
                out_d     = sym_s;
                x_nx_d    = x_next_s;
                out_vld_d = 1'b1;
                state_d   = ST_EMIT;
            end

            ST_EMIT: begin
                // x only advances once the symbol has actually been taken
                if (out_rdy) begin
                    out_vld_d = 1'b0;
                    x_d       = x_nx_q;
                    if (x_nx_q < L_MIN) begin
                        state_d = ST_RENORM;
                    end else if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = cnt_q - DATA_WIDTH'(1);
                        state_d = ST_DECODE;
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end

            ST_RENORM: begin
                if (in_hs_s) begin
                    case (cmd)
                        CMD_DATA: begin
                            x_d = x_shift_s;
                            if (x_shift_s < L_MIN) begin
                                state_d = ST_RENORM;
                            end else if (cnt_q == '0) begin
                                state_d = ST_IDLE;
                            end else begin
                                cnt_d   = cnt_q - DATA_WIDTH'(1);
                                state_d = ST_DECODE;
                            end
                        end
                        CMD_ABORT: begin
                            // Partial x is kept deliberately; the host may resume
                            state_d = ST_IDLE;
                        end
                        default: begin
                            // FREQ/STATE mid-stream are protocol errors; beat is dropped
                            err_d = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = ST_RENORM;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register bank with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            freq_q    <= '{default: '0};
            ptr_q     <= '0;
            x_q       <= '0;
            x_nx_q    <= '0;
            cnt_q     <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            freq_q    <= freq_d;
            ptr_q     <= ptr_d;
            x_q       <= x_d;
            x_nx_q    <= x_nx_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
            err_q     <= err_d;
        end
    end

    assign in_rdy  = in_rdy_s;
    assign out     = out_q;
    assign out_vld = out_vld_q;
    assign err     = err_q;

endmodule

// File: tb/tb_ans_decoder.sv
// -----------------------------------------------------------------------------
// tb_ans_decoder
//
// Self-checking bench for ans_decoder: a cycle-accurate vector table for the
// uniform-table walkthrough, hand-written sequences for backpressure, reset,
// bad START and renormalisation corners, then randomized streams checked
// against an arithmetic rANS model.
// -----------------------------------------------------------------------------
module tb_ans_decoder;

    localparam int L = 4096;

    localparam logic [1:0] C_FREQ  = 2'b00;
    localparam logic [1:0] C_STATE = 2'b01;
    localparam logic [1:0] C_DATA  = 2'b10;
    localparam logic [1:0] C_ABORT = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] din;
    logic [1:0] cmd;
    logic       in_vld;
    logic       in_rdy;
    logic [3:0] dout;
    logic       out_vld;
    logic       out_rdy;
    logic       err;

    int n_vec = 0;
    int n_mis = 0;

    int m_freq [16];
    int m_x;
    int exp_q [$];
    int nib_q [$];

    typedef struct {
        logic [1:0] c;
        logic [3:0] d;
        logic       v;
        logic       ordy;
        logic       e_vld;
        logic [3:0] e_out;
        logic       e_rdy;
        logic       e_err;
    } vec_t;

    vec_t vt [17];

    always #5 clk = ~clk;

    ans_decoder dut (
        .clk     (clk),
        .rst     (rst),
        .in      (din),
        .cmd     (cmd),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .out     (dout),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .err     (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Present one beat and hold it until the decoder takes it
    task automatic send(input logic [1:0] c, input logic [3:0] d);
        int w;
        w      = 0;
        cmd    = c;
        din    = d;
        in_vld = 1'b1;
        while (!in_rdy && w < 200) begin
            tick();
            w++;
        end
        if (!in_rdy) begin
            n_vec++;
            n_mis++;
            $display("FAIL send_timeout: in_rdy stayed 0 for 200 cycles, required 1");
        end else begin
            tick();
        end
        in_vld = 1'b0;
    endtask

    task automatic load_table();
        send(C_ABORT, 4'h0);
        for (int i = 0; i < 16; i++) begin
            send(C_FREQ, 4'(m_freq[i]));
        end
    endtask

    task automatic load_x(input int v);
        for (int k = 3; k >= 0; k--) begin
            send(C_STATE, 4'(v >> (4 * k)));
        end
        m_x = v;
    endtask

    task automatic expect_sym(input int exp, input string nm);
        int w;
        w       = 0;
        out_rdy = 1'b1;
        while (!out_vld && w < 50) begin
            tick();
            w++;
        end
        if (out_vld) begin
            chk(nm, dout, exp);
        end else begin
            n_vec++;
            n_mis++;
            $display("FAIL %s: out_vld still 0 after 50 cycles, required 1", nm);
        end
        tick();
    endtask

    // Reference rANS: decode cnt+1 symbols from m_x, drawing random refill nibbles
    task automatic model_run(input int cnt);
        int slot;
        int c;
        int s;
        int nb;
        exp_q.delete();
        nib_q.delete();
        for (int k = 0; k <= cnt; k++) begin
            slot = m_x % 16;
            c    = 0;
            s    = 0;
            while (s < 15 && !(m_freq[s] != 0 && slot < c + m_freq[s])) begin
                c += m_freq[s];
                s++;
            end
            exp_q.push_back(s);
            m_x = m_freq[s] * (m_x / 16) + slot - c;
            while (m_x < L) begin
                nb = $urandom_range(0, 15);
                nib_q.push_back(nb);
                m_x = m_x * 16 + nb;
            end
        end
    endtask

    task automatic rand_table();
        int nb;
        int off;
        int idx;
        nb  = $urandom_range(2, 16);
        off = $urandom_range(0, 15);
        for (int i = 0; i < 16; i++) m_freq[i] = 0;
        for (int u = 0; u < 16; u++) begin
            idx = (off + $urandom_range(0, nb - 1)) % 16;
            while (m_freq[idx] >= 15) idx = (idx + 1) % 16;
            m_freq[idx]++;
        end
    endtask

    task automatic rand_run(input int r);
        int cnt;
        if (r % 3 == 0) begin
            rand_table();
            load_table();
        end
        if (r == 0 || $urandom_range(0, 3) == 0) begin
            load_x($urandom_range(L, 65535));
        end
        cnt = $urandom_range(0, 15);
        model_run(cnt);
        fork
            begin
                send(C_DATA, 4'(cnt));
                foreach (nib_q[i]) send(C_DATA, 4'(nib_q[i]));
            end
            begin
                int got;
                int w;
                got = 0;
                w   = 0;
                while (got < exp_q.size() && w < 3000) begin
                    out_rdy = ($urandom_range(0, 3) != 0);
                    if (out_vld && out_rdy) begin
                        chk("rand_sym", dout, exp_q[got]);
                        got++;
                    end
                    tick();
                    w++;
                end
                if (got < exp_q.size()) begin
                    n_vec++;
                    n_mis++;
                    $display("FAIL rand_count: got %0d symbols, required %0d", got, exp_q.size());
                end
                out_rdy = 1'b1;
            end
        join
        tick();
        tick();
        chk("rand_idle_rdy", in_rdy, 1);
        chk("rand_err", err, 0);
        chk("rand_no_extra", out_vld, 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // c, d, v, ordy | e_vld, e_out, e_rdy, e_err
        vt[0]  = '{C_DATA,  4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0};
        vt[1]  = '{C_FREQ,  4'h0, 1'b0, 1'b1, 1'b1, 4'h4, 1'b0, 1'b0};
        vt[2]  = '{C_FREQ,  4'h0, 1'b0, 1'b1, 1'b0, 4'h4, 1'b1, 1'b0};
        vt[3]  = '{C_DATA,  4'hA, 1'b1, 1'b1, 1'b0, 4'h4, 1'b1, 1'b0};
        vt[4]  = '{C_DATA,  4'h0, 1'b1, 1'b0, 1'b0, 4'h4, 1'b0, 1'b0};
        vt[5]  = '{C_FREQ,  4'h0, 1'b0, 1'b0, 1'b1, 4'hA, 1'b0, 1'b0};
        vt[6]  = '{C_FREQ,  4'h0, 1'b0, 1'b0, 1'b1, 4'hA, 1'b0, 1'b0};
        vt[7]  = '{C_FREQ,  4'h0, 1'b0, 1'b1, 1'b0, 4'hA, 1'b1, 1'b0};
        vt[8]  = '{C_ABORT, 4'h0, 1'b1, 1'b1, 1'b0, 4'hA, 1'b1, 1'b0};
        vt[9]  = '{C_DATA,  4'h0, 1'b1, 1'b1, 1'b0, 4'hA, 1'b1, 1'b1};
        vt[10] = '{C_STATE, 4'h4, 1'b1, 1'b1, 1'b0, 4'hA, 1'b1, 1'b1};
        vt[11] = '{C_DATA,  4'h0, 1'b1, 1'b1, 1'b0, 4'hA, 1'b0, 1'b0};
        vt[12] = '{C_FREQ,  4'h0, 1'b0, 1'b1, 1'b1, 4'h4, 1'b0, 1'b0};
        vt[13] = '{C_FREQ,  4'h0, 1'b0, 1'b1, 1'b0, 4'h4, 1'b1, 1'b0};
        vt[14] = '{C_FREQ,  4'h7, 1'b1, 1'b1, 1'b0, 4'h4, 1'b1, 1'b1};
        vt[15] = '{C_ABORT, 4'h0, 1'b1, 1'b1, 1'b0, 4'h4, 1'b1, 1'b1};
        vt[16] = '{C_DATA,  4'h0, 1'b1, 1'b1, 1'b0, 4'h4, 1'b1, 1'b1};

        rst     = 1'b1;
        din     = 4'h0;
        cmd     = 2'b00;
        in_vld  = 1'b0;
        out_rdy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_vld", out_vld, 0);
        chk("rst_out", dout, 0);
        chk("rst_err", err, 0);
        chk("rst_in_rdy", in_rdy, 1);

        // Uniform table, x = 0x1234, then the cycle-exact vector walk
        for (int i = 0; i < 16; i++) m_freq[i] = 1;
        for (int i = 0; i < 16; i++) send(C_FREQ, 4'h1);
        load_x(32'h1234);
        for (int i = 0; i < 17; i++) begin
            cmd     = vt[i].c;
            din     = vt[i].d;
            in_vld  = vt[i].v;
            out_rdy = vt[i].ordy;
            tick();
            chk($sformatf("vec%0d_out_vld", i), out_vld, vt[i].e_vld);
            chk($sformatf("vec%0d_out", i), dout, vt[i].e_out);
            chk($sformatf("vec%0d_in_rdy", i), in_rdy, vt[i].e_rdy);
            chk($sformatf("vec%0d_err", i), err, vt[i].e_err);
        end
        in_vld = 1'b0;
        m_x    = 32'h123;

        // Two-symbol table: four symbols before the first renorm, with backpressure
        for (int i = 0; i < 16; i++) m_freq[i] = 0;
        m_freq[0] = 8;
        m_freq[1] = 8;
        load_table();
        load_x(32'h8000);
        out_rdy = 1'b0;
        send(C_DATA, 4'h3);
        chk("t2_err_clear", err, 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_out_vld", out_vld, 1);
            chk("bp_out", dout, 0);
            chk("bp_in_rdy", in_rdy, 0);
            tick();
        end
        out_rdy = 1'b1;
        tick();
        chk("bp_no_dup", out_vld, 0);
        expect_sym(0, "t2_sym1");
        expect_sym(0, "t2_sym2");
        expect_sym(0, "t2_sym3");
        chk("t2_renorm_rdy", in_rdy, 1);
        chk("t2_renorm_vld", out_vld, 0);
        send(C_DATA, 4'h5);
        chk("t2_idle_rdy", in_rdy, 1);
        tick();
        tick();
        chk("t2_idle_vld", out_vld, 0);
        m_x = 32'h8005;

        // Reset while a symbol is pending in EMIT
        send(C_DATA, 4'h4);
        for (int k = 0; k < 4; k++) expect_sym(0, "t3_sym");
        chk("t3_renorm_rdy", in_rdy, 1);
        send(C_FREQ, 4'h3);
        chk("t3_stray_freq_err", err, 1);
        out_rdy = 1'b0;
        send(C_DATA, 4'h0);
        tick();
        chk("t3_emit_vld", out_vld, 1);
        chk("t3_emit_err", err, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t3_rst_vld", out_vld, 0);
        chk("t3_rst_err", err, 0);
        chk("t3_rst_rdy", in_rdy, 1);
        chk("t3_rst_out", dout, 0);
        for (int i = 0; i < 16; i++) m_freq[i] = 0;
        load_x(32'h8000);
        send(C_DATA, 4'h0);
        chk("t3_cleared_table_err", err, 1);
        chk("t3_cleared_table_rdy", in_rdy, 1);

        // Table summing to 15 is rejected; a corrected table recovers
        for (int i = 0; i < 16; i++) m_freq[i] = (i == 15) ? 0 : 1;
        load_table();
        send(C_DATA, 4'h0);
        chk("bad_tbl_err", err, 1);
        chk("bad_tbl_rdy", in_rdy, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("bad_tbl_no_vld", out_vld, 0);
        end
        for (int i = 0; i < 16; i++) m_freq[i] = 1;
        load_table();
        send(C_DATA, 4'h0);
        chk("good_tbl_err", err, 0);
        chk("good_tbl_rdy", in_rdy, 0);
        expect_sym(0, "good_tbl_sym");
        chk("good_tbl_renorm", in_rdy, 1);
        send(C_DATA, 4'h0);
        m_x = 32'h8000;

        // State just below L is rejected
        load_x(32'h0FFF);
        send(C_DATA, 4'h0);
        chk("low_x_err", err, 1);
        chk("low_x_rdy", in_rdy, 1);
        tick();
        chk("low_x_no_vld", out_vld, 0);

        // Randomized streams against the reference model
        for (int r = 0; r < 40; r++) rand_run(r);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
